// File: rtl/ecc_csr_pkg.sv
// rtl/ecc_csr_pkg.sv - shared types, bit indices and field offsets for the ECC CSR bank
package ecc_csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_WR_ERR = 2;

    localparam int FIELD_KEY = 0;
    localparam int FIELD_PX  = 1;
    localparam int FIELD_PY  = 2;
    localparam int FIELD_QX  = 3;
    localparam int FIELD_QY  = 4;

    // Word offset of an operand/result field; fields are packed back to back.
    function automatic int field_base(input int field, input int words);
        return field * words;
    endfunction

endpackage

// File: rtl/ecc_csr_word.sv
// rtl/ecc_csr_word.sv - one bus-width register with per-byte write enables
module ecc_csr_word
    import ecc_csr_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   q
);

    // Byte-granular update; bytes whose enable is low keep their value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (be[b]) begin
                    q[b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ecc_csr_bank.sv
// rtl/ecc_csr_bank.sv - ECC point-multiply CSR bank; IRQ enable optional via ECC_CSR_IRQ_EN
module ecc_csr_bank
    import ecc_csr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int WORDS  = 8,
    parameter int ADDR_W = 6
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    AVL_READ,
    input  logic                    AVL_WRITE,
    input  logic [ADDR_W-1:0]       AVL_ADDR,
    input  logic [DATA_W/8-1:0]     AVL_BYTE_EN,
    input  logic [DATA_W-1:0]       AVL_WRITEDATA,
    output logic [DATA_W-1:0]       AVL_READDATA,
    output logic                    AVL_READDATAVALID,
    output logic [WORDS*DATA_W-1:0] KEY,
    output logic [WORDS*DATA_W-1:0] PX,
    output logic [WORDS*DATA_W-1:0] PY,
    output logic                    START,
    input  logic                    DONE_IN,
    input  logic [WORDS*DATA_W-1:0] QX_IN,
    input  logic [WORDS*DATA_W-1:0] QY_IN,
    output logic                    IRQ
);

    localparam int OP_WORDS = 3 * WORDS;
    localparam int KEY_BASE = field_base(FIELD_KEY, WORDS);
    localparam int PX_BASE  = field_base(FIELD_PX, WORDS);
    localparam int PY_BASE  = field_base(FIELD_PY, WORDS);
    localparam int QX_BASE  = field_base(FIELD_QX, WORDS);
    localparam int QY_BASE  = field_base(FIELD_QY, WORDS);
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'((1 << ADDR_W) - 2);
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'((1 << ADDR_W) - 1);

    state_t state_q, state_d;
    logic   start_d;
    logic   capture;
    logic   err_set;
    logic   wr_err_q;
    logic   irq_en;
    logic   busy;
    logic   done_flag;
    logic   ctrl_wr;
    logic   stat_wr;
    logic   op_wr;

    logic [DATA_W-1:0]       op_q [OP_WORDS];
    logic [WORDS*DATA_W-1:0] qx_q;
    logic [WORDS*DATA_W-1:0] qy_q;
    logic [DATA_W-1:0]       rd_mux;

    assign ctrl_wr   = AVL_WRITE && (AVL_ADDR == CTRL_ADDR);
    assign stat_wr   = AVL_WRITE && (AVL_ADDR == STAT_ADDR);
    assign op_wr     = AVL_WRITE && (AVL_ADDR < ADDR_W'(OP_WORDS));
    assign busy      = (state_q == ST_RUN);
    assign done_flag = (state_q == ST_DONE);
    assign IRQ       = done_flag & irq_en;

    // Operand storage: the lock drops every operand write while the core is running.
    for (genvar i = 0; i < OP_WORDS; i++) begin : g_op
        logic we;
        assign we = AVL_WRITE && !busy && (AVL_ADDR == ADDR_W'(i));
        ecc_csr_word #(.DATA_W(DATA_W)) u_word (
            .clk   (Clk),
            .rst_n (Reset_n),
            .we    (we),
            .be    (AVL_BYTE_EN),
            .wdata (AVL_WRITEDATA),
            .q     (op_q[i])
        );
    end

    for (genvar i = 0; i < WORDS; i++) begin : g_flat
        assign KEY[i*DATA_W +: DATA_W] = op_q[KEY_BASE + i];
        assign PX[i*DATA_W +: DATA_W]  = op_q[PX_BASE + i];
        assign PY[i*DATA_W +: DATA_W]  = op_q[PY_BASE + i];
    end

    // State register plus the registered start pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            START   <= 1'b0;
        end else begin
            state_q <= state_d;
            START   <= start_d;
        end
    end

    // Next state: DONE_IN wins over a coinciding CTRL write while running; START beats CLEAR.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        capture = 1'b0;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_wr && AVL_WRITEDATA[CTRL_START]) begin
                    start_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                err_set = op_wr || (ctrl_wr && AVL_WRITEDATA[CTRL_START]);
                if (DONE_IN) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ctrl_wr && AVL_WRITEDATA[CTRL_START]) begin
                    start_d = 1'b1;
                    state_d = ST_RUN;
                end else if (ctrl_wr && AVL_WRITEDATA[CTRL_CLEAR]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result capture; only a completion seen while running updates the results.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            qx_q <= '0;
            qy_q <= '0;
        end else if (capture) begin
            qx_q <= QX_IN;
            qy_q <= QY_IN;
        end
    end

    // Sticky write-error flag; write-one-to-clear through STATUS.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_err_q <= 1'b0;
        end else if (stat_wr && AVL_WRITEDATA[STAT_WR_ERR]) begin
            wr_err_q <= 1'b0;
        end else if (err_set) begin
            wr_err_q <= 1'b1;
        end
    end

`ifdef ECC_CSR_IRQ_EN
    logic ctrl_take;
    assign ctrl_take = ctrl_wr && !(busy && DONE_IN);

    // IRQ enable follows every CTRL write that is not swallowed by a completion.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            irq_en <= 1'b0;
        end else if (ctrl_take) begin
            irq_en <= AVL_WRITEDATA[CTRL_IRQ_EN];
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    // Read mux over the current register state; unmapped addresses return zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < OP_WORDS; i++) begin
            if (AVL_ADDR == ADDR_W'(i)) begin
                rd_mux = op_q[i];
            end
        end
        for (int i = 0; i < WORDS; i++) begin
            if (AVL_ADDR == ADDR_W'(QX_BASE + i)) begin
                rd_mux = qx_q[i*DATA_W +: DATA_W];
            end
            if (AVL_ADDR == ADDR_W'(QY_BASE + i)) begin
                rd_mux = qy_q[i*DATA_W +: DATA_W];
            end
        end
        if (AVL_ADDR == CTRL_ADDR) begin
            rd_mux[CTRL_IRQ_EN] = irq_en;
        end
        if (AVL_ADDR == STAT_ADDR) begin
            rd_mux[STAT_BUSY]   = busy;
            rd_mux[STAT_DONE]   = done_flag;
            rd_mux[STAT_WR_ERR] = wr_err_q;
        end
    end

    // Registered read response; a read paired with a write is dropped.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            AVL_READDATA      <= '0;
            AVL_READDATAVALID <= 1'b0;
        end else if (AVL_READ && !AVL_WRITE) begin
            AVL_READDATA      <= rd_mux;
            AVL_READDATAVALID <= 1'b1;
        end else begin
            AVL_READDATAVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ecc_csr_bank.sv
// tb/tb_ecc_csr_bank.sv - scoreboard bench for ecc_csr_bank with a register-level model
module tb_ecc_csr_bank;

    localparam int DW = 32;
    localparam int W  = 8;
    localparam int AW = 6;

    logic            Clk = 1'b0;
    logic            Reset_n = 1'b0;
    logic            AVL_READ = 1'b0;
    logic            AVL_WRITE = 1'b0;
    logic [AW-1:0]   AVL_ADDR = '0;
    logic [DW/8-1:0] AVL_BYTE_EN = '0;
    logic [DW-1:0]   AVL_WRITEDATA = '0;
    logic [DW-1:0]   AVL_READDATA;
    logic            AVL_READDATAVALID;
    logic [W*DW-1:0] KEY, PX, PY;
    logic            START;
    logic            DONE_IN = 1'b0;
    logic [W*DW-1:0] QX_IN = '0;
    logic [W*DW-1:0] QY_IN = '0;
    logic            IRQ;

    ecc_csr_bank #(.DATA_W(DW), .WORDS(W), .ADDR_W(AW)) dut (
        .Clk               (Clk),
        .Reset_n           (Reset_n),
        .AVL_READ          (AVL_READ),
        .AVL_WRITE         (AVL_WRITE),
        .AVL_ADDR          (AVL_ADDR),
        .AVL_BYTE_EN       (AVL_BYTE_EN),
        .AVL_WRITEDATA     (AVL_WRITEDATA),
        .AVL_READDATA      (AVL_READDATA),
        .AVL_READDATAVALID (AVL_READDATAVALID),
        .KEY               (KEY),
        .PX                (PX),
        .PY                (PY),
        .START             (START),
        .DONE_IN           (DONE_IN),
        .QX_IN             (QX_IN),
        .QY_IN             (QY_IN),
        .IRQ               (IRQ)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_t;

    rd_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    // Reference model: plain register contents and run flags.
    logic [31:0] m_op [24];
    logic [31:0] m_qx [8];
    logic [31:0] m_qy [8];
    bit m_busy, m_done, m_err, m_irq_en;
    int start_due = -1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 24; i++) m_op[i] = '0;
        for (int i = 0; i < 8; i++) begin
            m_qx[i] = '0;
            m_qy[i] = '0;
        end
        m_busy = 0; m_done = 0; m_err = 0; m_irq_en = 0;
        start_due = -1;
    endtask

    function automatic logic [31:0] model_read(input int a);
        if (a < 24) return m_op[a];
        if (a < 32) return m_qx[a-24];
        if (a < 40) return m_qy[a-32];
        if (a == 62) return {29'd0, m_irq_en, 2'b00};
        if (a == 63) return {29'd0, m_err, m_done, m_busy};
        return 32'd0;
    endfunction

    task automatic model_update(input bit wr, input int a, input logic [3:0] be,
                                input logic [31:0] d, input bit dn);
        bit was_busy;
        bit finish;
        was_busy = m_busy;
        finish   = was_busy && dn;
        if (wr) begin
            if (a < 24) begin
                if (was_busy) m_err = 1;
                else for (int b = 0; b < 4; b++) if (be[b]) m_op[a][b*8 +: 8] = d[b*8 +: 8];
            end else if (a == 62) begin
                if (was_busy) begin
                    if (d[0]) m_err = 1;
`ifdef ECC_CSR_IRQ_EN
                    if (!finish) m_irq_en = d[2];
`endif
                end else begin
`ifdef ECC_CSR_IRQ_EN
                    m_irq_en = d[2];
`endif
                    if (d[0]) begin
                        m_busy = 1;
                        m_done = 0;
                        start_due = cyc;
                    end else if (d[1]) begin
                        m_done = 0;
                    end
                end
            end else if (a == 63) begin
                if (d[2]) m_err = 0;
            end
        end
        if (finish) begin
            m_busy = 0;
            m_done = 1;
            for (int i = 0; i < 8; i++) begin
                m_qx[i] = QX_IN[i*32 +: 32];
                m_qy[i] = QY_IN[i*32 +: 32];
            end
        end
    endtask

    // One bus cycle; expected read data comes from the model state before the edge.
    task automatic step(input bit rd, input bit wr, input logic [5:0] a, input logic [3:0] be,
                        input logic [31:0] d, input bit dn, input bit use_c, input logic [31:0] cexp);
        logic [31:0] exp;
        AVL_READ = rd; AVL_WRITE = wr; AVL_ADDR = a;
        AVL_BYTE_EN = be; AVL_WRITEDATA = d; DONE_IN = dn;
        exp = use_c ? cexp : model_read(int'(a));
        @(posedge Clk);
        #1;
        model_update(wr, int'(a), be, d, dn);
        if (rd && !wr) sb_q.push_back('{exp, cyc});
        AVL_READ = 0; AVL_WRITE = 0; DONE_IN = 0;
    endtask

    task automatic wr_w(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        step(0, 1, a, be, d, 0, 0, 32'd0);
    endtask

    task automatic rd_c(input logic [5:0] a, input logic [31:0] c);
        step(1, 0, a, 4'h0, 32'd0, 0, 1, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 6'd0, 4'h0, 32'd0, 0, 0, 32'd0);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        model_reset();
        sb_q.delete();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    // Monitor: pops read responses and compares the continuously visible outputs.
    always @(negedge Clk) begin
        if (mon_en) begin
            if (AVL_READDATAVALID) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdv: readdatavalid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    rd_t e;
                    e = sb_q.pop_front();
                    chk("rd_latency", 256'(cyc), 256'(e.due));
                    chk("rd_data", 256'(AVL_READDATA), 256'(e.data));
                end
            end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_rdv: readdatavalid=0 expected 1 (cycle %0d)", cyc);
                void'(sb_q.pop_front());
            end
            begin
                logic [255:0] ek, ex, ey;
                for (int i = 0; i < 8; i++) begin
                    ek[i*32 +: 32] = m_op[i];
                    ex[i*32 +: 32] = m_op[8+i];
                    ey[i*32 +: 32] = m_op[16+i];
                end
                chk("key", KEY, ek);
                chk("px", PX, ex);
                chk("py", PY, ey);
            end
            chk("start", 256'(START), 256'(cyc == start_due));
            chk("irq", 256'(IRQ), 256'(m_done & m_irq_en));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        mon_en = 1'b1;

        // Every address reads zero after reset, back to back.
        for (int a = 0; a < 64; a++) rd_c(6'(a), 32'd0);
        idle(1);

        // Byte-enable merge on KEY[0].
        wr_w(6'd0, 32'hFFFF_FFFF, 4'hF);
        wr_w(6'd0, 32'h0000_0000, 4'h5);
        rd_c(6'd0, 32'hFF00_FF00);
        wr_w(6'd1, 32'h1234_5678, 4'h0);
        rd_c(6'd1, 32'h0000_0000);

        // Start, locked operand write, sticky error and its clear.
        wr_w(6'd62, 32'h5, 4'hF);
        rd_c(6'd63, 32'h1);
        wr_w(6'd8, 32'hDEAD_BEEF, 4'hF);
        rd_c(6'd63, 32'h5);
        rd_c(6'd8, 32'h0);
        wr_w(6'd63, 32'h4, 4'hF);
        rd_c(6'd63, 32'h1);

        // Completion captures results; CLEAR returns to idle.
        QX_IN = '0;
        QX_IN[31:0] = 32'h1234_5678;
        QY_IN = '0;
        QY_IN[63:32] = 32'h9ABC_DEF0;
        step(0, 0, 6'd0, 4'h0, 32'd0, 1, 0, 32'd0);
        rd_c(6'd63, 32'h2);
        rd_c(6'd24, 32'h1234_5678);
        rd_c(6'd33, 32'h9ABC_DEF0);
        wr_w(6'd62, 32'h2, 4'hF);
        rd_c(6'd63, 32'h0);

        // Reset during a run; a later completion is ignored.
        wr_w(6'd62, 32'h1, 4'hF);
        idle(2);
        do_reset();
        QX_IN[31:0] = 32'hCAFE_F00D;
        step(0, 0, 6'd0, 4'h0, 32'd0, 1, 0, 32'd0);
        rd_c(6'd63, 32'h0);
        rd_c(6'd24, 32'h0);

        // Simultaneous read and write: write lands, no response.
        step(1, 1, 6'd1, 4'hF, 32'hA5A5_A5A5, 0, 0, 32'd0);
        idle(1);
        rd_c(6'd1, 32'hA5A5_A5A5);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [5:0]  a;
            logic [3:0]  be;
            logic [31:0] d;
            bit rd, wr, dn;
            int r, k;
            r = $urandom_range(0, 9);
            if (r < 5)      a = 6'($urandom_range(0, 41));
            else if (r < 7) a = 6'd62;
            else if (r < 8) a = 6'd63;
            else            a = 6'($urandom);
            k  = $urandom_range(0, 9);
            rd = (k < 4) || (k == 8);
            wr = (k >= 4) && (k <= 8);
            dn = ($urandom_range(0, 7) == 0);
            be = 4'($urandom);
            d  = $urandom;
            for (int i = 0; i < 8; i++) begin
                QX_IN[i*32 +: 32] = $urandom;
                QY_IN[i*32 +: 32] = $urandom;
            end
            step(rd, wr, a, be, d, dn, 0, 32'd0);
        end

        idle(3);
        chk("sb_drained", 256'(sb_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecc_csr_bank.md
# ecc_csr_bank

Parametrised Avalon-MM control/status register bank sitting between the bus slave and the elliptic-curve point-multiply core. Holds the private key and base-point operands with arbitrary per-byte write enables. Provides read-only result registers captured from the core. Sequences the start/busy/done handshake with an operand write lock and a sticky error flag.

## Interface
- DATA_W, 32, bus word width; must be a multiple of 8
- WORDS, 8, words per operand field (8 × 32 = 256-bit operands)
- ADDR_W, 6, word-address width; 5·WORDS + 2 ≤ 2^ADDR_W

Ports (clock and reset first):
- Clk  in  1  single system clock
- Reset_n  in  1  asynchronous, active-low reset
- AVL_READ  in  1  read strobe
- AVL_WRITE  in  1  write strobe
- AVL_ADDR  in  ADDR_W  word address
- AVL_BYTE_EN  in  DATA_W/8  per-byte write enable
- AVL_WRITEDATA  in  DATA_W  write data
- AVL_READDATA  out  DATA_W  registered read data
- AVL_READDATAVALID  out  1  one-cycle pulse qualifying AVL_READDATA
- KEY, PX, PY  out  WORDS·DATA_W each  flattened operands; word 0 is the LSW
- START  out  1  one-cycle start pulse to the core
- DONE_IN  in  1  one-cycle completion pulse from the core
- QX_IN, QY_IN  in  WORDS·DATA_W each  result buses, valid while DONE_IN = 1
- IRQ  out  1  level interrupt

## Operation
- Address map, word addresses:
  - 0..W-1 KEY
  - W..2W-1 PX
  - 2W..3W-1 PY
  - 3W..4W-1 QX (read-only)
  - 4W..5W-1 QY (read-only)
  - 2^ADDR_W-2 CTRL
  - 2^ADDR_W-1 STATUS
  - All other addresses read 0; writes to them are dropped.
- Operand writes: each byte i is updated only if AVL_BYTE_EN[i] = 1; any enable pattern is legal, and BYTE_EN = 0 writes nothing.
- CTRL bits (write-only, reads 0 except bit 2):
  - bit0 START
  - bit1 CLEAR
  - bit2 IRQ_EN (stored)
- STATUS bits:
  - bit0 BUSY
  - bit1 DONE
  - bit2 WR_ERR, sticky; writing 1 to this bit clears it
  - other bits read 0
- State machine IDLE → RUN → DONE:
  - IDLE, CTRL write with START = 1: START pulses, go to RUN.
  - RUN:
    - Operand writes are dropped and set WR_ERR.
    - A CTRL START write is ignored and sets WR_ERR.
    - DONE_IN = 1: capture QX_IN/QY_IN, go to DONE.
  - DONE:
    - CLEAR = 1: go to IDLE.
    - START = 1: START pulses, go to RUN, DONE cleared.
    - START and CLEAR both set: START wins.
    - Operand writes are permitted.
  - DONE_IN outside RUN is ignored; result registers keep their old values.
- Reads of QX/QY return the last captured result.
- IRQ = STATUS.DONE & IRQ_EN.
- AVL_READ and AVL_WRITE together: the write is performed, the read is ignored, and no READDATAVALID is issued.

## Timing
- Reset values: all registers 0, state IDLE, START = 0, AVL_READDATAVALID = 0, AVL_READDATA = 0, IRQ = 0.
- Reset mid-RUN aborts immediately to IDLE; a later DONE_IN is ignored.
- Write takes effect at the clock edge where AVL_WRITE = 1; KEY/PX/PY reflect the new value the following cycle.
- Read latency 1: READDATAVALID is high the cycle after AVL_READ is sampled.
  - Data reflects register state at the sampling edge; a write one cycle earlier is visible.
  - Back-to-back reads are supported, one per cycle.
- START pulses exactly one cycle, the cycle after the CTRL write. BUSY = 1 from that same cycle.
- DONE_IN sampled at edge N:
  - DONE = 1, BUSY = 0 and the captured results are visible from cycle N+1.
  - IRQ is asserted at N+1.
- A CTRL write coinciding with DONE_IN in RUN: DONE_IN is processed and the CTRL write is ignored (sets WR_ERR if START = 1).

## Configuration
- ECC_CSR_IRQ_EN:
  - Defined: IRQ_EN bit is stored and readable, and IRQ is driven as above.
  - Undefined: IRQ_EN is not implemented (CTRL bit2 reads 0, writes ignored), and IRQ is tied 0; polling via STATUS only.

## Structure
- Package ecc_csr_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - CTRL/STATUS bit-index constants
  - field base-offset localparams derived from WORDS
- Sub-module ecc_csr_word: one DATA_W register with byte-enable merge, asynchronous active-low reset, and a write-enable input. Instantiated 3·WORDS times via generate.
- Result capture, FSM and read mux live in the top module.

## Test plan
- Reset, then read every address: all return 0 with READDATAVALID exactly 1 cycle after each read; IRQ = 0.
- Write KEY[0] = 0xFFFFFFFF, then BYTE_EN = 4'b0101 with data 0x00000000 → readback 0xFF00FF00; KEY[31:0] matches.
- Write CTRL = 0x5, then write PX[0] during RUN:
  - START pulses one cycle.
  - STATUS = 0x1 before the PX write; STATUS = 0x5 after it.
  - PX is unchanged.
  - Writing STATUS = 0x4 clears WR_ERR.
- In RUN, pulse DONE_IN with QX_IN word 0 = 0x12345678: next cycle STATUS = 0x2, IRQ = 1 (with macro), QX[0] reads 0x12345678. CTRL = 0x2 → STATUS = 0x0, IRQ = 0.
- Assert Reset_n low mid-RUN, release, then pulse DONE_IN → STATUS stays 0, QX reads 0.
- AVL_READ and AVL_WRITE together on KEY[1] = 0xA5A5A5A5 → no READDATAVALID; the next read returns 0xA5A5A5A5.
